spart_tx_queue: RTL and testbench

- Upstream feeder for spart_top's transmit side.
- Buffers 24-bit game messages (shots, hit/miss replies) written by the processor/board logic in a FIFO.
- Drives spart_top's one-cycle send_tx strobe and its tx_data word, spacing strobes so each serial frame completes before the next launches.
- Producers can fire messages back-to-back without knowing spart timing.

---
 rtl/spart_tx_queue.sv | 143 ++++++++++++++
 tb/tb_spart_tx_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_queue.sv
// Transmit-side feeder for spart_top: FIFO of DATA_W-bit messages, one send_tx
// strobe per message, spaced so each serial frame finishes before the next launch.
//
// state | meaning
// IDLE  | waiting for a queued message; pops the head into tx_data when one exists
// SEND  | send_tx high for this single cycle; gap timer loaded
// GAP   | frame in flight; gap timer counts down to zero, then back to IDLE
module spart_tx_queue #(
  parameter int DATA_W     = 24,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_overflow,
  output logic                     send_tx,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_overflow;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [GAP_W-1:0]    w_gap_nxt;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_accept;

  // Status comes only from registered count, so wr_en never reaches an output.
  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_wr_accept = wr_en && !w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_gap_nxt   = GAP_LOAD;
        w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Storage is not reset; only entries behind an accepted write are ever read.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      unique case ({w_wr_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A dropped write outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign send_tx  = (r_state == SEND);
  assign tx_data  = r_tx_data;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign busy     = (r_state != IDLE) || !w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_spart_tx_queue.sv
// Scoreboard bench for spart_tx_queue: stimulus pushes expected messages, a
// negedge monitor pops and compares on every send_tx strobe.
module tb_spart_tx_queue;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;
  localparam int GAP    = 100;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                gap_check;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              clr_overflow = 1'b0;
  logic              send_tx;
  logic [DATA_W-1:0] tx_data;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              busy;
  logic              overflow;

  exp_t              sb[$];
  int                nvec = 0;
  int                nerr = 0;
  int                cyc = 0;
  int                last_pulse = 0;
  int                pulse_cnt = 0;
  logic              prev_send = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  spart_tx_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .clr_overflow(clr_overflow), .send_tx(send_tx), .tx_data(tx_data),
    .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_write(input logic [DATA_W-1:0] d, input bit expect_it, input bit gap_chk);
    exp_t e;
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_it) begin
      e.data      = d;
      e.gap_check = gap_chk;
      sb.push_back(e);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", {31'd0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (send_tx) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_pulse: got tx_data %0h expected no strobe (cycle %0d)", tx_data, cyc);
      end else begin
        e = sb.pop_front();
        check("tx_data", {8'd0, tx_data}, {8'd0, e.data});
        if (e.gap_check) check("pulse_spacing", cyc - last_pulse, GAP + 2);
      end
      last_pulse = cyc;
      pulse_cnt++;
    end
    if (prev_send && !rst) check("tx_hold_after_strobe", {8'd0, tx_data}, {8'd0, prev_data});
    prev_send = send_tx;
    prev_data = tx_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pc;
    logic [DATA_W-1:0] v;

    // Reset values
    repeat (3) tick();
    rst = 1'b0;
    check("rst_send_tx", {31'd0, send_tx}, 0);
    check("rst_tx_data", {8'd0, tx_data}, 0);
    check("rst_count", {{(32-CW){1'b0}}, count}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);

    // Single message: strobe 2 cycles after write, busy drops after the gap
    push_write(24'hbeefde, 1'b1, 1'b0);
    check("t1_no_strobe_yet", {31'd0, send_tx}, 0);
    check("t1_count_one", {{(32-CW){1'b0}}, count}, 1);
    tick();
    check("t1_strobe", {31'd0, send_tx}, 1);
    check("t1_count_zero", {{(32-CW){1'b0}}, count}, 0);
    repeat (100) tick();
    check("t1_busy_in_gap", {31'd0, busy}, 1);
    tick();
    check("t1_busy_drop", {31'd0, busy}, 0);
    check("t1_empty", {31'd0, empty}, 1);

    // Three back-to-back writes
    push_write(24'h000001, 1'b1, 1'b0);
    push_write(24'h000002, 1'b1, 1'b1);
    push_write(24'h000003, 1'b1, 1'b1);
    check("t2_count", {{(32-CW){1'b0}}, count}, 2);
    wait_idle(1000);

    // Fill while in GAP, overflow and its clear
    push_write(24'h100000, 1'b1, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 9; i++) begin
      v = 24'ha00001 + DATA_W'(i);
      push_write(v, i < 8, 1'b1);
      if (i == 7) begin
        check("t3_full", {31'd0, full}, 1);
        check("t3_count8", {{(32-CW){1'b0}}, count}, 8);
        check("t3_no_ovf_yet", {31'd0, overflow}, 0);
      end
    end
    check("t3_overflow", {31'd0, overflow}, 1);
    check("t3_count_after_drop", {{(32-CW){1'b0}}, count}, 8);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_cleared", {31'd0, overflow}, 0);
    clr_overflow = 1'b1;
    push_write(24'hdead00, 1'b0, 1'b0);
    clr_overflow = 1'b0;
    check("t3_set_wins", {31'd0, overflow}, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_cleared2", {31'd0, overflow}, 0);
    wait_idle(3000);

    // Write coinciding with the pop of the only entry
    push_write(24'h444441, 1'b1, 1'b0);
    push_write(24'h444442, 1'b1, 1'b1);
    check("t4_count_stays", {{(32-CW){1'b0}}, count}, 1);
    check("t4_not_empty", {31'd0, empty}, 0);
    check("t4_strobe", {31'd0, send_tx}, 1);
    wait_idle(1000);

    // Reset mid-GAP with 3 queued entries
    push_write(24'h555500, 1'b1, 1'b0);
    push_write(24'h555501, 1'b0, 1'b0);
    push_write(24'h555502, 1'b0, 1'b0);
    push_write(24'h555503, 1'b0, 1'b0);
    check("t5_count3", {{(32-CW){1'b0}}, count}, 3);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_send_tx", {31'd0, send_tx}, 0);
    check("t5_tx_data", {8'd0, tx_data}, 0);
    check("t5_count", {{(32-CW){1'b0}}, count}, 0);
    check("t5_empty", {31'd0, empty}, 1);
    check("t5_busy", {31'd0, busy}, 0);
    pc = pulse_cnt;
    repeat (300) tick();
    check("t5_no_pulse_after_rst", pulse_cnt, pc);

    // Wrap-around: five bursts of four, count never above 3
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 4; i++) begin
        v = 24'h600000 + DATA_W'(b * 4 + i);
        push_write(v, 1'b1, i != 0);
      end
      check("t6_count3", {{(32-CW){1'b0}}, count}, 3);
      wait_idle(1000);
    end
    check("t6_overflow", {31'd0, overflow}, 0);

    repeat (5) tick();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
